// File: rtl/gda_pkg.sv
// Shared types and default sizing for the GDA recover sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gda_pkg;

  localparam int GDA_W     = 8;
  localparam int GDA_P     = 6;
  localparam int GDA_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    CORRECT = 2'd2,
    HOLD    = 2'd3
  } gda_state_t;

endpackage

// File: rtl/gda_recover_seq_if.sv
// Operand/result handshake bundle plus error statistic for gda_recover_seq.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface gda_recover_seq_if
  import gda_pkg::*;
#(
  parameter int W     = GDA_W,
  parameter int CNT_W = GDA_CNT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in1;
  logic [W-1:0]     in2;
  logic             approx_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       res;
  logic             err_flag;
  logic [CNT_W-1:0] err_count;
  logic             clr_count;

  // Operand source and result consumer side
  modport master (
    output in_valid, in1, in2, approx_mode, out_ready, clr_count,
    input  in_ready, out_valid, res, err_flag, err_count
  );

  // Adder block side
  modport slave (
    input  in_valid, in1, in2, approx_mode, out_ready, clr_count,
    output in_ready, out_valid, res, err_flag, err_count
  );

endinterface

// File: rtl/gda_pred_add.sv
// Windowed carry-prediction adder: each carry only looks back P bit positions.
// Latency: combinational.
// Backpressure: none.
module gda_pred_add
  import gda_pkg::*;
#(
  parameter int W = GDA_W,
  parameter int P = GDA_P
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum,
  output logic [W:0]   carry
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic         win_c;

  assign g = a & b;
  assign p = a ^ b;

  // Ripple a fresh carry (starting at 0) through the window below each bit;
  // j >= i-P also covers the max(0, i-P) clamp when i-P is negative.
  always_comb begin
    carry = '0;
    win_c = 1'b0;
    for (int i = 1; i <= W; i++) begin
      win_c = 1'b0;
      for (int j = 0; j < W; j++) begin
        if ((j >= i - P) && (j < i)) begin
          win_c = g[j] | (p[j] & win_c);
        end
      end
      carry[i] = win_c;
    end
    sum = {carry[W], p ^ carry[W-1:0]};
  end

endmodule

// File: rtl/gda_recover_seq.sv
// Approximate adder wrapper: predicted sum after EVAL, optional exact fix-up.
// Latency: 2 cycles from handshake cycle to out_valid, 3 when corrected.
// Backpressure: single operation in flight; result held in HOLD until out_ready.
module gda_recover_seq
  import gda_pkg::*;
#(
  parameter int W     = GDA_W,
  parameter int P     = GDA_P,
  parameter int CNT_W = GDA_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  gda_recover_seq_if.slave   bus
);

  gda_state_t   state;
  gda_state_t   nxt;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         mode_q;
  logic [W:0]   pred_sum;
  logic [W:0]   pred_c;
  logic [W:0]   exact_sum;
  logic [W:0]   exact_c;
  logic         mism;

  gda_pred_add #(.W(W), .P(P)) u_pred (
    .a     (a_q),
    .b     (b_q),
    .sum   (pred_sum),
    .carry (pred_c)
  );

  assign exact_sum = {1'b0, a_q} + {1'b0, b_q};
  // Exact carry into each bit recovered from the true sum. Sum bits differ
  // exactly where carries differ, so this is the same as comparing sums.
  assign exact_c   = exact_sum ^ {1'b0, a_q ^ b_q};
  assign mism      = (pred_c != exact_c);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: correction detour only for exact mode on a misprediction
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) nxt = EVAL;
      EVAL:    nxt = (mism && !mode_q) ? CORRECT : HOLD;
      CORRECT: nxt = HOLD;
      HOLD:    if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand capture and result register; res/err_flag frozen outside EVAL/CORRECT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= 1'b0;
      bus.res      <= '0;
      bus.err_flag <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_q    <= bus.in1;
        b_q    <= bus.in2;
        mode_q <= bus.approx_mode;
      end
      if (state == EVAL && (!mism || mode_q)) begin
        bus.res      <= pred_sum;
        bus.err_flag <= mism;
      end
      if (state == CORRECT) begin
        bus.res      <= exact_sum;
        bus.err_flag <= 1'b1;
      end
    end
  end

  // Saturating misprediction counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err_count <= '0;
    end else if (bus.clr_count) begin
      bus.err_count <= '0;
    end else if (state == EVAL && mism && (bus.err_count != {CNT_W{1'b1}})) begin
      bus.err_count <= bus.err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gda_recover_seq.sv
// Scoreboard bench for gda_recover_seq with a 4-bit error counter.
// Latency: checked per result against hand-computed 2/3 cycle figures.
// Backpressure: result stability and single transfer checked while stalled.
module tb_gda_recover_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gda_recover_seq_if #(.W(8), .CNT_W(4)) bus ();

  gda_recover_seq #(.W(8), .P(6), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] res;
    logic       flag;
    logic [3:0] cnt;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         total   = 0;
  int         bad     = 0;
  int         cyc     = 0;
  int         t0      = 0;
  int         t1      = 0;
  int         n_xfer  = 0;
  int         exp_cnt = 0;
  logic       prev_ov = 1'b0;
  logic       prev_or = 1'b0;
  logic [8:0] prev_res = '0;
  logic       prev_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: latency bookkeeping, stall stability, scoreboard pop on transfer
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) t0 = cyc;
      if (bus.out_valid && !prev_ov) t1 = cyc;
      if (bus.out_valid && prev_ov && !prev_or) begin
        chk("stall_res_stable", 32'(bus.res), 32'(prev_res));
        chk("stall_flag_stable", 32'(bus.err_flag), 32'(prev_flag));
      end
      if (bus.out_valid) chk("in_ready_low_busy", 32'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res", 32'(bus.res), 32'(e.res));
          chk("err_flag", 32'(bus.err_flag), 32'(e.flag));
          chk("err_count", 32'(bus.err_count), 32'(e.cnt));
          chk("latency", 32'(t1 - t0), 32'(e.lat));
        end
      end
      prev_ov   = bus.out_valid;
      prev_or   = bus.out_ready;
      prev_res  = bus.res;
      prev_flag = bus.err_flag;
    end
  end

  // One operation: push expectation, hand over operands, optionally stall the result
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [8:0] er, input logic ef, input int lat,
                       input int hold, input logic clr);
    exp_t e;
    int   n;
    int   x0;
    if (clr) exp_cnt = 0;
    else if (ef && exp_cnt < 15) exp_cnt++;
    e.res = er; e.flag = ef; e.cnt = 4'(exp_cnt); e.lat = lat;
    sb.push_back(e);
    x0 = n_xfer;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) chk("timeout_in_ready", 0, 1);
    bus.in1 = a; bus.in2 = b; bus.approx_mode = m; bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    // Operands are latched; scramble the inputs to show they are ignored now
    bus.in_valid = 1'b0; bus.in1 = ~a; bus.in2 = ~b; bus.approx_mode = ~m;
    bus.clr_count = clr;
    @(posedge clk); #1;
    bus.clr_count = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.out_valid) chk("timeout_out_valid", 0, 1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("held_valid", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("out_valid_drop", 32'(bus.out_valid), 0);
    chk("one_transfer", 32'(n_xfer - x0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.approx_mode = 1'b0;
    bus.out_ready = 1'b1; bus.clr_count = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_res", 32'(bus.res), 0);
    chk("rst_err_flag", 32'(bus.err_flag), 0);
    chk("rst_err_count", 32'(bus.err_count), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    //     a      b      mode res     flag lat hold clr
    do_op(8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 2, 0, 1'b0);
    do_op(8'h3F, 8'h01, 1'b0, 9'h040, 1'b0, 2, 0, 1'b0); // chain fits window
    do_op(8'h80, 8'h80, 1'b0, 9'h100, 1'b0, 2, 0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 3, 0, 1'b0); // corrected
    do_op(8'hFF, 8'h01, 1'b1, 9'h080, 1'b1, 2, 0, 1'b0); // predicted returned
    do_op(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0, 2, 5, 1'b0); // backpressure
    do_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 3, 3, 1'b0); // stall after fix-up

    for (int k = 0; k < 17; k++) do_op(8'hFF, 8'h01, 1'b1, 9'h080, 1'b1, 2, 0, 1'b0);
    chk("cnt_saturated", 32'(bus.err_count), 32'hF);

    do_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 3, 0, 1'b1); // clear beats increment
    do_op(8'hFF, 8'h01, 1'b1, 9'h080, 1'b1, 2, 0, 1'b0);

    // Abort an operation while it sits in CORRECT
    bus.in1 = 8'h7F; bus.in2 = 8'h01; bus.approx_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sb.delete();
    exp_cnt = 0;
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_res", 32'(bus.res), 0);
    chk("abort_err_flag", 32'(bus.err_flag), 0);
    chk("abort_err_count", 32'(bus.err_count), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 2, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
